// File: rtl/fir_pkg.sv
// Shared sizing helpers for the FIR adder tree.
//   tree_levels  : number of adder levels for a given tap count
//   accu_bits    : accumulator width that cannot overflow across the tree
//   tree_latency : register stages from accept to out_valid
//   accu_word_t  : signed accumulator word, wide enough for any legal config
package fir_pkg;

    localparam int ACCU_MAX = 64;

    typedef logic signed [ACCU_MAX-1:0] accu_word_t;

    function automatic int tree_levels(input int taps);
        return $clog2(taps);
    endfunction

    function automatic int accu_bits(input int multbits, input int taps);
        return multbits + tree_levels(taps);
    endfunction

    // One stage per REG_EVERY levels, rounded up so the last level is always
    // registered; the round/saturate option adds one output stage.
    function automatic int tree_latency(input int taps, input int reg_every, input int round_en);
        int lv;
        lv = tree_levels(taps);
        return (lv + reg_every - 1) / reg_every + round_en;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic shift and saturation of the full
// tree sum down to the output sample width.
//   sum  in  ACCUBITS  signed full-precision sum
//   data out OUTBITS   signed rounded, shifted, clipped sample
//   sat  out 1         data was clipped to the output range
module fir_round_sat #(
    parameter int ACCUBITS = 41,
    parameter int SHIFT    = 15,
    parameter int OUTBITS  = 16
) (
    input  logic [ACCUBITS-1:0] sum,
    output logic [OUTBITS-1:0]  data,
    output logic                sat
);

    // One guard bit so the rounding add cannot wrap.
    localparam int W = ACCUBITS + 1;
    localparam logic signed [W-1:0] HALF =
        (SHIFT > 0) ? W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0) : '0;
    localparam logic signed [W-1:0] MAXV = {{(W-OUTBITS+1){1'b0}}, {(OUTBITS-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {{(W-OUTBITS+1){1'b1}}, {(OUTBITS-1){1'b0}}};

    logic signed [W-1:0] ext;
    logic signed [W-1:0] rnd;
    logic signed [W-1:0] shifted;

    always_comb begin
        ext     = {sum[ACCUBITS-1], sum};
        rnd     = ext + HALF;
        shifted = rnd >>> SHIFT;
        data    = shifted[OUTBITS-1:0];
        sat     = 1'b0;
        if (shifted > MAXV) begin
            data = MAXV[OUTBITS-1:0];
            sat  = 1'b1;
        end else if (shifted < MINV) begin
            data = MINV[OUTBITS-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/fir_adder_tree_pipe.sv
// Pipelined signed binary adder tree summing TAPS multiplier products into one
// FIR output sample, with valid/ready handshake and a global stall.
// Optional feature macro: FIR_TREE_ROUND_SAT_EN (round half up + saturate,
// one extra output register stage, drives sat_flag).
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   product vector handshake (in_ready = stage advance)
//   products[0:TAPS-1]  signed tap products
//   out_valid/out_ready output sample handshake
//   out_data            signed output sample = sum >> SHIFT (wrapped or clipped)
//   sat_flag            sample was clipped (0 when the macro is absent)
module fir_adder_tree_pipe
    import fir_pkg::*;
#(
    parameter int TAPS      = 401,
    parameter int MULTBITS  = 32,
    parameter int REG_EVERY = 1,
    parameter int OUTBITS   = 16,
    parameter int SHIFT     = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MULTBITS-1:0] products [0:TAPS-1],
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUTBITS-1:0]  out_data,
    output logic                sat_flag
);

    localparam int LEVELS   = tree_levels(TAPS);
    localparam int ACCUBITS = accu_bits(MULTBITS, TAPS);
    localparam int P        = 1 << LEVELS;
`ifdef FIR_TREE_ROUND_SAT_EN
    localparam int ROUND_EN = 1;
`else
    localparam int ROUND_EN = 0;
`endif
    localparam int STAGES   = tree_latency(TAPS, REG_EVERY, ROUND_EN);

    logic              adv;
    logic [STAGES:1]   vld_pipe;
    logic [ACCUBITS-1:0] tree_sum;

    // Whole pipe moves together; it only freezes when a finished sample is
    // waiting on the consumer.
    assign out_valid = vld_pipe[STAGES];
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;

    // A cycle with in_valid=0 shifts in a bubble that travels like data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (adv) begin
            vld_pipe[1] <= in_valid;
            for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    // Level 0 holds the sign-extended inputs (zero padding above TAPS);
    // level k holds P>>k partial sums, registered where the spacing says so.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int N = P >> k;
        logic [ACCUBITS-1:0] q [0:N-1];

        if (k == 0) begin : g_in
            for (genvar i = 0; i < N; i++) begin : g_tap
                if (i < TAPS) begin : g_real
                    assign q[i] = {{LEVELS{products[i][MULTBITS-1]}}, products[i]};
                end else begin : g_pad
                    assign q[i] = '0;
                end
            end
        end else begin : g_add
            logic [ACCUBITS-1:0] sum [0:N-1];
            for (genvar i = 0; i < N; i++) begin : g_node
                assign sum[i] = g_lvl[k-1].q[2*i] + g_lvl[k-1].q[2*i+1];
            end
            if ((k % REG_EVERY) == 0 || k == LEVELS) begin : g_reg
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)   q <= '{default: '0};
                    else if (adv) q <= sum;
                end
            end else begin : g_comb
                assign q = sum;
            end
        end
    end

    assign tree_sum = g_lvl[LEVELS].q[0];

`ifdef FIR_TREE_ROUND_SAT_EN
    logic [OUTBITS-1:0] rs_data;
    logic               rs_sat;

    fir_round_sat #(
        .ACCUBITS (ACCUBITS),
        .SHIFT    (SHIFT),
        .OUTBITS  (OUTBITS)
    ) u_round_sat (
        .sum  (tree_sum),
        .data (rs_data),
        .sat  (rs_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            sat_flag <= 1'b0;
        end else if (adv) begin
            out_data <= rs_data;
            sat_flag <= rs_sat;
        end
    end
`else
    // Truncating slice: upper bits dropped, so the sample wraps.
    logic unused_tree_bits;
    assign unused_tree_bits = ^tree_sum;
    assign out_data         = tree_sum[SHIFT+OUTBITS-1:SHIFT];
    assign sat_flag         = 1'b0;
`endif

endmodule
